// File: rtl/pad_reader.sv
// Dual serial game-pad reader: latches both pads, clocks out 16 bits from
// each and publishes the active-high button state atomically.
//
// state | meaning
// IDLE  | waiting for poll_start, pad_clk idles high
// LATCH | pad_latch high for LATCH_CYCLES cycles
// HIGH  | pad_clk high for HALF_PERIOD cycles, data captured on last cycle
// LOW   | pad_clk low for HALF_PERIOD cycles, then next bit
// DONE  | one cycle, publishes shift registers on the following edge
module pad_reader #(
    parameter int LATCH_CYCLES = 300,
    parameter int HALF_PERIOD  = 150
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        poll_start,
    input  logic [1:0]  pad_data_in,
    input  logic        overrun_clear,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] pad_state_0,
    output logic [15:0] pad_state_1,
    output logic        busy,
    output logic        state_valid,
    output logic        overrun
);

    localparam int MAX_CYC = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, LATCH, HIGH, LOW, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   sh0_q, sh0_d, sh1_q, sh1_d;
    logic [15:0]   pad_state_0_q, pad_state_0_d, pad_state_1_q, pad_state_1_d;
    logic          pad_latch_q, pad_latch_d, pad_clk_q, pad_clk_d;
    logic          busy_q, busy_d, state_valid_q, state_valid_d;
    logic          overrun_q, overrun_d;

    // Next-state, phase down-counter, bit capture and registered-output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        pad_state_0_d = pad_state_0_q;
        pad_state_1_d = pad_state_1_q;
        state_valid_d = 1'b0;
        overrun_d     = overrun_q;

        case (state_q)
            IDLE: begin
                if (poll_start) begin
                    state_d = LATCH;
                    cnt_d   = LATCH_LOAD;
                    idx_d   = 4'd0;
                end
            end
            LATCH: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = HALF_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    sh0_d[idx_q] = ~pad_data_in[0];
                    sh1_d[idx_q] = ~pad_data_in[1];
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOW;
                        cnt_d   = HALF_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = HALF_LOAD;
                    idx_d   = idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                pad_state_0_d = sh0_q;
                pad_state_1_d = sh1_q;
                state_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Set has priority over clear
        if (overrun_clear) overrun_d = 1'b0;
        if (poll_start && (state_q != IDLE)) overrun_d = 1'b1;

        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d != LOW);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= 4'd0;
            sh0_q         <= 16'h0000;
            sh1_q         <= 16'h0000;
            pad_state_0_q <= 16'h0000;
            pad_state_1_q <= 16'h0000;
            pad_latch_q   <= 1'b0;
            pad_clk_q     <= 1'b1;
            busy_q        <= 1'b0;
            state_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            sh0_q         <= sh0_d;
            sh1_q         <= sh1_d;
            pad_state_0_q <= pad_state_0_d;
            pad_state_1_q <= pad_state_1_d;
            pad_latch_q   <= pad_latch_d;
            pad_clk_q     <= pad_clk_d;
            busy_q        <= busy_d;
            state_valid_q <= state_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign pad_latch   = pad_latch_q;
    assign pad_clk     = pad_clk_q;
    assign pad_state_0 = pad_state_0_q;
    assign pad_state_1 = pad_state_1_q;
    assign busy        = busy_q;
    assign state_valid = state_valid_q;
    assign overrun     = overrun_q;

endmodule
